uart_rx_oversampled: RTL and testbench

//  Standalone oversampling UART receiver: 8 data bits, LSB first, optional parity, 1 stop bit.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_rx_oversampled_if.sv | 11 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_oversampled.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM state type and baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// uart_rx_oversampled_if: valid/ready byte delivery channel of the UART receiver.
interface uart_rx_oversampled_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divide-by-DIV oversample tick generator with synchronous restart.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_div_chk
        $error("uart_baud_tick: DIV must be >= 1");
    end

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (restart || cnt_q == '0) ? W'(DIV - 1) : cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= W'(DIV - 1);
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8-bit oversampling UART receiver with majority vote and error flags.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int USE_PARITY = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    uart_rx_oversampled_if.master  bus,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   overrun_err,
    output logic                   rx_busy
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;

    rx_state_t    state_q, state_d;
    logic [1:0]   sync_q, sync_d;
    logic [OSW-1:0] os_q, os_d;
    logic [2:0]   bit_q, bit_d;
    logic [7:0]   sh_q, sh_d;
    logic         s0_q, s0_d, s1_q, s1_d, perr_q, perr_d;
    logic         frame_err_q, parity_err_q, overrun_err_q;
    logic         rx_s, tick, restart, vote, at_vote, at_end, done, ferr, ppulse, ovr;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    assign rx_s    = sync_q[1];
    assign vote    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    assign at_vote = tick && os_q == OSW'(M + 1);
    assign at_end  = tick && os_q == OSW'(OVERSAMPLE - 1);

    always_comb begin
        sync_d  = {sync_q[0], rx};
        state_d = state_q;
        os_d    = os_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        perr_d  = perr_q;
        restart = 1'b0;
        done    = 1'b0;
        ferr    = 1'b0;
        ppulse  = 1'b0;
        if (state_q != IDLE && state_q != BREAK && tick) begin
            os_d = at_end ? '0 : os_q + 1'b1;
            s0_d = (os_q == OSW'(M - 1)) ? rx_s : s0_q;
            s1_d = (os_q == OSW'(M)) ? rx_s : s1_q;
        end
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                os_d    = '0;
                bit_d   = '0;
                perr_d  = 1'b0;
                restart = 1'b1;
            end
            START: state_d = (at_vote && vote) ? IDLE : (at_end ? DATA : START);
            DATA: begin
                sh_d = at_vote ? {vote, sh_q[7:1]} : sh_q;
                if (at_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = (USE_PARITY != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                perr_d  = at_vote ? (vote != (^sh_q ^ (PARITY_ODD != 0))) : perr_q;
                state_d = at_end ? STOP : PARITY;
            end
            STOP: if (at_vote) begin
                // decided mid-bit so the next start edge can be caught early
                state_d = vote ? IDLE : BREAK;
                done    = vote & !perr_q;
                ppulse  = vote & perr_q;
                ferr    = !vote;
            end
            BREAK: state_d = rx_s ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sync_q        <= 2'b11;
            os_q          <= '0;
            bit_q         <= '0;
            sh_q          <= '0;
            s0_q          <= 1'b1;
            s1_q          <= 1'b1;
            perr_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            os_q          <= os_d;
            bit_q         <= bit_d;
            sh_q          <= sh_d;
            s0_q          <= s0_d;
            s1_q          <= s1_d;
            perr_q        <= perr_d;
            frame_err_q   <= ferr;
            parity_err_q  <= ppulse;
            overrun_err_q <= ovr;
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        pop, push, full;

    always_comb begin
        full  = (cnt_q == (AW + 1)'(FIFO_DEPTH));
        pop   = (cnt_q != '0) & bus.rx_ready;
        push  = done & (!full | pop);
        ovr   = done & full & !pop;
        rd_d  = rd_q + AW'(pop);
        wr_d  = wr_q + AW'(push);
        cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= sh_q;
    end

    assign bus.rx_valid = (cnt_q != '0);
    assign bus.rx_data  = (cnt_q != '0) ? mem_q[rd_q] : 8'h00;
`else
    logic       valid_q, valid_d, accept, load;
    logic [7:0] data_q, data_d;

    always_comb begin
        accept  = valid_q & bus.rx_ready;
        load    = done & (!valid_q | accept);
        ovr     = done & valid_q & !accept;
        valid_d = done | (valid_q & !accept);
        data_d  = load ? sh_q : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.rx_valid = valid_q;
    assign bus.rx_data  = data_q;
`endif

    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;
    assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: scoreboard bench, 8N1 receiver (dut0) and even-parity receiver (dut1).
module tb_uart_rx_oversampled;

    localparam int BIT = 160;
    localparam logic [9:0] EV_FRM = 10'h100;
    localparam logic [9:0] EV_PAR = 10'h200;
    localparam logic [9:0] EV_OVR = 10'h300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1;
    logic ferr0, perr0, oerr0, busy0, ferr1, perr1, oerr1, busy1;
    int   tests = 0, fails = 0;
    logic [9:0] q0[$], q1[$];

    uart_rx_oversampled_if bus0 ();
    uart_rx_oversampled_if bus1 ();
    assign bus0.rx_ready = rdy0;
    assign bus1.rx_ready = rdy1;

    always #5 clk = ~clk;

    uart_rx_oversampled #(.CLK_FREQ(1_536_000), .BAUD_RATE(9600), .OVERSAMPLE(16),
                          .USE_PARITY(0), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .bus(bus0),
        .frame_err(ferr0), .parity_err(perr0), .overrun_err(oerr0), .rx_busy(busy0));

    uart_rx_oversampled #(.CLK_FREQ(1_536_000), .BAUD_RATE(9600), .OVERSAMPLE(16),
                          .USE_PARITY(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .bus(bus1),
        .frame_err(ferr1), .parity_err(perr1), .overrun_err(oerr1), .rx_busy(busy1));

    task automatic chk(input int d, input logic [9:0] got);
        logic [9:0] exp;
        tests++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            fails++;
            $display("FAIL sb%0d unexpected event got=%h expected none", d, got);
        end else begin
            if (d == 0) exp = q0.pop_front();
            else        exp = q1.pop_front();
            if (exp !== got) begin
                fails++;
                $display("FAIL sb%0d event got=%h expected=%h", d, got, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus0.rx_valid && bus0.rx_ready) chk(0, {2'b00, bus0.rx_data});
            if (ferr0) chk(0, EV_FRM);
            if (perr0) chk(0, EV_PAR);
            if (oerr0) chk(0, EV_OVR);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus1.rx_valid && bus1.rx_ready) chk(1, {2'b00, bus1.rx_data});
            if (ferr1) chk(1, EV_FRM);
            if (perr1) chk(1, EV_PAR);
            if (oerr1) chk(1, EV_OVR);
        end
    end

    task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic v);
        if (d == 0) rx0 = v;
        else        rx1 = v;
    endtask

    task automatic wait_bits(input int n);
        repeat (n * BIT) @(negedge clk);
    endtask

    task automatic send(input int d, input logic [7:0] b, input bit par_en, input bit par, input bit stop);
        drive(d, 1'b0);
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            drive(d, b[i]);
            wait_bits(1);
        end
        if (par_en) begin
            drive(d, par);
            wait_bits(1);
        end
        drive(d, stop);
        wait_bits(1);
    endtask

    task automatic outputs_zero(input string tag);
        expect_eq({tag, "_valid"}, {31'd0, bus0.rx_valid}, 0);
        expect_eq({tag, "_data"}, {24'd0, bus0.rx_data}, 0);
        expect_eq({tag, "_errs"}, {29'd0, ferr0, perr0, oerr0}, 0);
        expect_eq({tag, "_busy"}, {31'd0, busy0}, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst_n = 1'b1;
        wait_bits(1);

        // 1: plain 8N1 byte
        q0.push_back(10'h0A5);
        send(0, 8'hA5, 0, 0, 1);
        wait_bits(1);

        // 2: short glitch must not start a frame
        rx0 = 1'b0;
        repeat (3) @(negedge clk);
        rx0 = 1'b1;
        repeat (2) @(negedge clk);
        expect_eq("glitch_busy_rise", {31'd0, busy0}, 1);
        n = 0;
        while (busy0 && n < BIT) begin
            @(negedge clk);
            n++;
        end
        expect_eq("glitch_busy_fall", {31'd0, busy0}, 0);
        wait_bits(1);

        // 3: framing error followed by a break, then a good byte
        q0.push_back(EV_FRM);
        q0.push_back(10'h055);
        send(0, 8'h3C, 0, 0, 0);
        wait_bits(2);
        rx0 = 1'b1;
        wait_bits(2);
        send(0, 8'h55, 0, 0, 1);
        wait_bits(1);

        // 4: even parity on 0x07 requires parity bit 1
        q1.push_back(EV_PAR);
        send(1, 8'h07, 1, 0, 1);
        wait_bits(1);
        q1.push_back(10'h007);
        send(1, 8'h07, 1, 1, 1);
        wait_bits(1);

        // 5: consumer stalled
        rdy0 = 1'b0;
`ifdef UART_RX_FIFO_EN
        q0.push_back(EV_OVR);
        for (int i = 1; i <= 4; i++) q0.push_back(10'(i));
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 0, 1);
        wait_bits(1);
        expect_eq("stall_valid", {31'd0, bus0.rx_valid}, 1);
        expect_eq("stall_head", {24'd0, bus0.rx_data}, 32'h01);
`else
        q0.push_back(EV_OVR);
        q0.push_back(10'h011);
        send(0, 8'h11, 0, 0, 1);
        send(0, 8'h22, 0, 0, 1);
        wait_bits(1);
        expect_eq("stall_valid", {31'd0, bus0.rx_valid}, 1);
        expect_eq("stall_data", {24'd0, bus0.rx_data}, 32'h11);
`endif
        rdy0 = 1'b1;
        wait_bits(1);

        // 6: reset during data bit 4 abandons the frame
        fork
            send(0, 8'h96, 0, 0, 1);
            begin
                repeat (5 * BIT + BIT / 2) @(negedge clk);
                expect_eq("busy_before_rst", {31'd0, busy0}, 1);
                rst_n = 1'b0;
                #1;
                outputs_zero("midrst");
            end
        join
        wait_bits(1);
        rst_n = 1'b1;
        wait_bits(1);
        q0.push_back(10'h0C3);
        send(0, 8'hC3, 0, 0, 1);
        wait_bits(2);

        expect_eq("sb0_drained", q0.size(), 0);
        expect_eq("sb1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
